result_accum_ctrl: RTL and testbench
====================================

Name: result_accum_ctrl

Overview:
Read-modify-write sequencer for the dual-port result RAM of the sparse CNN accelerator. Accepts scattered partial-sum updates (address, value) from the PE array and accumulates them into the RAM. Port 0 does the reads and port 1 does the writes, with one-deep forwarding for back-to-back hits. Also clears the RAM before a layer and drains it sequentially to the output writer after the layer.

Parameters:
DWIDTH, 32, data/accumulator width (two's complement, wrap-around)
AWIDTH, 4, RAM address width
MEM_SIZE, 16, number of RAM words (≤ 2^AWIDTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_clear  in  1  pulse: zero all words (honoured in IDLE only)
start_drain  in  1  pulse: stream all words out (honoured in IDLE only)
acc_valid  in  1  update valid
acc_ready  out  1  update accepted when valid&ready
acc_addr  in  AWIDTH  target word
acc_data  in  DWIDTH  signed partial sum
acc_last  in  1  final update of the layer
out_valid  out  1  drain word valid
out_ready  in  1  downstream accept
out_addr  out  AWIDTH  address of drain word
out_data  out  DWIDTH  drain word
out_last  out  1  with word MEM_SIZE-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of CLEAR, FLUSH or DRAIN
ram_addr0/ram_ce0/ram_we0  out  AWIDTH/1/1  RAM port 0 (read only; we0 tied 0)
ram_q0  in  DWIDTH  port 0 read data, 1-cycle latency, holds when ce0=0
ram_addr1/ram_ce1/ram_we1/ram_d1  out  AWIDTH/1/1/DWIDTH  RAM port 1 (write only)

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; acc_ready, out_valid, out_last, busy, done, all ce/we = 0; pipeline valid bits and forward register cleared. An operation in progress is abandoned; RAM contents are undefined.
- FSM states: IDLE, CLEAR, ACCUM, FLUSH, DRAIN_RD, DRAIN_OUT.
- IDLE: acc_ready=1. Priority: start_clear → CLEAR; else start_drain → DRAIN_RD; else an accepted update → ACCUM, and that update enters the pipeline. Commands outside IDLE are ignored.
- CLEAR: counter 0..MEM_SIZE-1; port 1 writes 0, one word per cycle. After the last write → IDLE with done pulse. Takes MEM_SIZE cycles.
- ACCUM: acc_ready=1. The pipeline has two stages:
  - S0 (accept cycle t): ram_ce0=1, ram_addr0=acc_addr; address and data are registered into S1.
  - S1 (cycle t+1): sum = base + data1, where base = fwd_data if (fwd_valid && fwd_addr==addr1), else ram_q0. Port 1 writes sum to addr1 (ce1=we1=1). fwd_addr/fwd_data/fwd_valid are loaded with addr1/sum/1. Otherwise fwd_valid=0.
  - Forwarding covers the case where a write and a read to the same address hit the same edge; the RAM returns the old value in that case. Any update stream is correct at full throughput (1 update/cycle).
  - Gaps in acc_valid are allowed; S1 idles.
  - Accepted update with acc_last=1 → FLUSH; acc_ready=0 from the next cycle.
- FLUSH: the S1 of the last update completes (1 cycle) → IDLE with done pulse.
- DRAIN_RD: ce0=1, addr0=cnt → DRAIN_OUT.
- DRAIN_OUT: out_valid=1, out_data=ram_q0, out_addr=cnt, out_last=(cnt==MEM_SIZE-1). Outputs hold stable until out_ready.
  - On handshake: if last → IDLE with done pulse, else cnt+1 and → DRAIN_RD.
  - Each word takes at least 2 cycles.
- Arithmetic: DWIDTH-bit two's-complement add, overflow wraps, no saturation.
- Ports 0 and 1 never address the same word with we=1 on both ports; we0 is always 0.

Test Plan:
1. Reset, start_clear → 16 port-1 writes of 0 at addrs 0..15, done pulses on the 16th cycle after accept. Then drain → out_data all 0, out_last on addr 15.
2. Clear, then updates (3,+5),(7,-2),(3,+10,last) with gaps → drain gives addr3=15, addr7=-2 (0xFFFFFFFE), all others 0.
3. Back-to-back same address: 4 consecutive cycles to addr 2 with data 1,2,3,4 → addr2=10. This proves forwarding.
4. Alternating addrs 1,2,1,2 every cycle with data 1 → addr1=2, addr2=2. Forwarding must not fire on mismatched addresses.
5. Overflow: addr0 = 0x7FFFFFFF then +1 → 0x80000000.
6. Drain with out_ready held low 5 cycles on word 4 → out_data/out_addr stable throughout, no skipped or duplicated words. rst_n=0 mid-drain → IDLE next cycle, out_valid=0, busy=0.

Source files
------------

// File: rtl/result_accum_if.sv
// Update and drain streams of the result accumulator.
// The design takes the slave side; the PE array and the output writer take the master side.
interface result_accum_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 4
);
  logic                     acc_valid;
  logic                     acc_ready;
  logic [AWIDTH-1:0]        acc_addr;
  logic signed [DWIDTH-1:0] acc_data;
  logic                     acc_last;
  logic                     out_valid;
  logic                     out_ready;
  logic [AWIDTH-1:0]        out_addr;
  logic signed [DWIDTH-1:0] out_data;
  logic                     out_last;

  modport slave (
    input  acc_valid, acc_addr, acc_data, acc_last, out_ready,
    output acc_ready, out_valid, out_addr, out_data, out_last
  );

  modport master (
    output acc_valid, acc_addr, acc_data, acc_last, out_ready,
    input  acc_ready, out_valid, out_addr, out_data, out_last
  );
endinterface

// File: rtl/result_accum_ctrl.sv
// Read-modify-write sequencer for the dual-port result RAM: clear, scattered
// accumulate with one-deep write->read forwarding, and sequential drain.
module result_accum_ctrl #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 4,
  parameter int MEM_SIZE = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_clear,
  input  logic                     start_drain,
  result_accum_if.slave            bus,
  output logic                     busy,
  output logic                     done,
  output logic [AWIDTH-1:0]        ram_addr0,
  output logic                     ram_ce0,
  output logic                     ram_we0,
  input  logic signed [DWIDTH-1:0] ram_q0,
  output logic [AWIDTH-1:0]        ram_addr1,
  output logic                     ram_ce1,
  output logic                     ram_we1,
  output logic signed [DWIDTH-1:0] ram_d1
);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(MEM_SIZE - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, FLUSH, DRAIN_RD, DRAIN_OUT} state_t;

  state_t                   state, state_nxt;
  logic [AWIDTH-1:0]        cnt, cnt_nxt;
  logic                     accept;
  logic                     vld_p1;
  logic [AWIDTH-1:0]        addr_p1;
  logic signed [DWIDTH-1:0] data_p1;
  logic                     fwd_vld;
  logic [AWIDTH-1:0]        fwd_addr;
  logic signed [DWIDTH-1:0] fwd_data;
  logic signed [DWIDTH-1:0] base_p1, sum_p1;

  function automatic logic signed [DWIDTH-1:0] wrap_add(
    input logic signed [DWIDTH-1:0] a,
    input logic signed [DWIDTH-1:0] b
  );
    return a + b;
  endfunction

  // S1: the RAM returns the pre-write value when a write to the same word
  // shares the edge with the read, so the forward register supplies it instead.
  always_comb begin
    base_p1 = (fwd_vld && (fwd_addr == addr_p1)) ? fwd_data : ram_q0;
    sum_p1  = wrap_add(base_p1, data_p1);
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    accept        = 1'b0;
    done          = 1'b0;
    bus.acc_ready = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_addr  = cnt;
    bus.out_data  = ram_q0;
    bus.out_last  = 1'b0;
    ram_addr0     = bus.acc_addr;
    ram_ce0       = 1'b0;
    ram_addr1     = addr_p1;
    ram_ce1       = vld_p1;
    ram_we1       = vld_p1;
    ram_d1        = sum_p1;
    unique case (state)
      IDLE: begin
        // Updates are held off while a command is being taken so none is lost.
        bus.acc_ready = rst_n && !start_clear && !start_drain;
        accept        = bus.acc_valid && bus.acc_ready;
        if (start_clear) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end else if (start_drain) begin
          state_nxt = DRAIN_RD;
          cnt_nxt   = '0;
        end else if (accept) begin
          ram_ce0   = 1'b1;
          state_nxt = bus.acc_last ? FLUSH : ACCUM;
        end
      end
      CLEAR: begin
        ram_addr1 = cnt;
        ram_ce1   = 1'b1;
        ram_we1   = 1'b1;
        ram_d1    = '0;
        if (cnt == LAST_ADDR) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + AWIDTH'(1);
        end
      end
      ACCUM: begin
        bus.acc_ready = 1'b1;
        accept        = bus.acc_valid;
        if (accept) begin
          ram_ce0 = 1'b1;
          if (bus.acc_last) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      DRAIN_RD: begin
        ram_ce0   = 1'b1;
        ram_addr0 = cnt;
        state_nxt = DRAIN_OUT;
      end
      DRAIN_OUT: begin
        bus.out_valid = 1'b1;
        bus.out_last  = (cnt == LAST_ADDR);
        if (bus.out_ready) begin
          if (cnt == LAST_ADDR) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = cnt + AWIDTH'(1);
            state_nxt = DRAIN_RD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ram_we0 = 1'b0;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      vld_p1  <= 1'b0;
      fwd_vld <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vld_p1  <= accept;
      fwd_vld <= vld_p1;
    end
  end

  // S0 -> S1 and S1 -> forward register
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1 <= bus.acc_addr;
      data_p1 <= bus.acc_data;
    end
    if (vld_p1) begin
      fwd_addr <= addr_p1;
      fwd_data <= sum_p1;
    end
  end
endmodule

// File: tb/tb_result_accum_ctrl.sv
// Directed bench for result_accum_ctrl: clear, accumulate scenarios, stalled
// drain and reset during drain, against hand-computed RAM images.
module tb_result_accum_ctrl;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int MS = 16;

  logic clk = 1'b0;
  logic rst_n, start_clear, start_drain, busy, done;
  logic [AW-1:0] ram_addr0, ram_addr1;
  logic ram_ce0, ram_we0, ram_ce1, ram_we1;
  logic signed [DW-1:0] ram_q0, ram_d1;
  logic signed [DW-1:0] mem [MS];

  int passed = 0;
  int total  = 0;

  result_accum_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

  result_accum_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS)) dut (
    .clk(clk), .rst_n(rst_n), .start_clear(start_clear), .start_drain(start_drain),
    .bus(bus), .busy(busy), .done(done),
    .ram_addr0(ram_addr0), .ram_ce0(ram_ce0), .ram_we0(ram_we0), .ram_q0(ram_q0),
    .ram_addr1(ram_addr1), .ram_ce1(ram_ce1), .ram_we1(ram_we1), .ram_d1(ram_d1)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: read-before-write on a same-word collision.
  always @(posedge clk) begin
    if (ram_ce0) ram_q0 <= mem[ram_addr0];
    if (ram_ce1 && ram_we1) mem[ram_addr1] <= ram_d1;
  end

  typedef struct {
    int          scen;
    logic        vld;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        last;
  } upd_t;

  typedef struct {
    int          scen;
    logic [3:0]  addr;
    logic [31:0] val;
  } exp_t;

  upd_t vec[$];
  exp_t expv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] exp_word(input int scen, input int addr);
    logic [31:0] v = 32'h0;
    foreach (expv[i])
      if (expv[i].scen == scen && int'(expv[i].addr) == addr) v = expv[i].val;
    return v;
  endfunction

  task automatic do_clear();
    start_clear = 1'b1;
    @(negedge clk);
    start_clear = 1'b0;
    for (int i = 0; i < MS; i++) begin
      chk($sformatf("clear ctl %0d", i), {25'h0, ram_ce1, ram_we1, done, ram_addr1},
          {25'h0, 1'b1, 1'b1, (i == MS - 1), 4'(i)});
      chk($sformatf("clear d1 %0d", i), ram_d1, 32'h0);
      @(negedge clk);
    end
    chk("clear busy after", {31'h0, busy}, 32'h0);
  endtask

  task automatic run_updates(input int scen);
    int n = 0;
    foreach (vec[i]) begin
      if (vec[i].scen == scen) begin
        bus.acc_valid = vec[i].vld;
        bus.acc_addr  = vec[i].addr;
        bus.acc_data  = vec[i].data;
        bus.acc_last  = vec[i].last;
        if (vec[i].vld) chk($sformatf("s%0d acc_ready", scen), {31'h0, bus.acc_ready}, 32'h1);
        @(negedge clk);
      end
    end
    bus.acc_valid = 1'b0;
    bus.acc_last  = 1'b0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("s%0d flush done", scen), {31'h0, done}, 32'h1);
    chk($sformatf("s%0d flush acc_ready", scen), {31'h0, bus.acc_ready}, 32'h0);
    @(negedge clk);
    chk($sformatf("s%0d busy after flush", scen), {31'h0, busy}, 32'h0);
  endtask

  task automatic drain(input int scen, input int stall);
    int e = 0, waitc = 0, held = 0;
    logic [3:0]  sa;
    logic [31:0] sd;
    start_drain   = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    start_drain = 1'b0;
    chk($sformatf("s%0d drain busy", scen), {31'h0, busy}, 32'h1);
    while (e < MS) begin
      if (waitc > 400) begin
        chk($sformatf("s%0d drain timeout words", scen), e, MS);
        break;
      end
      if (bus.out_valid) begin
        if (held == 0) begin
          chk($sformatf("s%0d out_addr %0d", scen, e), {28'h0, bus.out_addr}, e);
          chk($sformatf("s%0d out_data %0d", scen, e), bus.out_data, exp_word(scen, e));
          chk($sformatf("s%0d out_last %0d", scen, e), {31'h0, bus.out_last}, {31'h0, e == MS - 1});
          sa = bus.out_addr;
          sd = bus.out_data;
        end else begin
          chk($sformatf("s%0d stall hold %0d", scen, held), {bus.out_addr, bus.out_data[27:0]},
              {sa, sd[27:0]});
          chk($sformatf("s%0d stall data %0d", scen, held), bus.out_data, sd);
        end
        if (e == stall && held < 5) begin
          held++;
          bus.out_ready = 1'b0;
        end else begin
          bus.out_ready = 1'b1;
          if (e == MS - 1) begin
            #1;
            chk($sformatf("s%0d drain done", scen), {31'h0, done}, 32'h1);
          end
          e++;
          held = 0;
        end
      end else begin
        bus.out_ready = 1'b0;
      end
      @(negedge clk);
      waitc++;
    end
    bus.out_ready = 1'b0;
    chk($sformatf("s%0d busy after drain", scen), {31'h0, busy}, 32'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // scen, vld, addr, data, last
    vec.push_back('{2, 1'b1, 4'd3, 32'd5,        1'b0});
    vec.push_back('{2, 1'b0, 4'd0, 32'd0,        1'b0});
    vec.push_back('{2, 1'b1, 4'd7, 32'hFFFFFFFE, 1'b0});
    vec.push_back('{2, 1'b0, 4'd0, 32'd0,        1'b0});
    vec.push_back('{2, 1'b0, 4'd0, 32'd0,        1'b0});
    vec.push_back('{2, 1'b1, 4'd3, 32'd10,       1'b1});
    vec.push_back('{3, 1'b1, 4'd2, 32'd1,        1'b0});
    vec.push_back('{3, 1'b1, 4'd2, 32'd2,        1'b0});
    vec.push_back('{3, 1'b1, 4'd2, 32'd3,        1'b0});
    vec.push_back('{3, 1'b1, 4'd2, 32'd4,        1'b1});
    vec.push_back('{4, 1'b1, 4'd1, 32'd1,        1'b0});
    vec.push_back('{4, 1'b1, 4'd2, 32'd1,        1'b0});
    vec.push_back('{4, 1'b1, 4'd1, 32'd1,        1'b0});
    vec.push_back('{4, 1'b1, 4'd2, 32'd1,        1'b1});
    vec.push_back('{5, 1'b1, 4'd0, 32'h7FFFFFFF, 1'b0});
    vec.push_back('{5, 1'b1, 4'd0, 32'd1,        1'b1});
    expv.push_back('{2, 4'd3, 32'd15});
    expv.push_back('{2, 4'd7, 32'hFFFFFFFE});
    expv.push_back('{3, 4'd2, 32'd10});
    expv.push_back('{4, 4'd1, 32'd2});
    expv.push_back('{4, 4'd2, 32'd2});
    expv.push_back('{5, 4'd0, 32'h80000000});

    rst_n = 1'b0;
    start_clear = 1'b0;
    start_drain = 1'b0;
    bus.acc_valid = 1'b0;
    bus.acc_addr  = '0;
    bus.acc_data  = '0;
    bus.acc_last  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset status", {27'h0, busy, done, bus.out_valid, bus.out_last, bus.acc_ready}, 32'h0);
    chk("reset ram ctl", {28'h0, ram_ce0, ram_we0, ram_ce1, ram_we1}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle acc_ready", {31'h0, bus.acc_ready}, 32'h1);

    do_clear();
    drain(1, -1);
    for (int s = 2; s <= 5; s++) begin
      do_clear();
      run_updates(s);
      drain(s, (s == 2) ? 4 : -1);
    end

    // Reset in the middle of a drain abandons it.
    start_drain   = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    start_drain = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid-drain busy", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset mid-drain", {30'h0, bus.out_valid, busy}, 32'h0);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("idle after reset", {30'h0, bus.acc_ready, busy}, 32'h2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
